// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver sampling path.
// Holds default widths, prescale limits and the small combinational helpers
// (3-way majority vote, prescale legality) used by the sampler and counter.
package uart_rx_pkg;

  localparam int unsigned PRESCALE_W_DEF = 6;
  localparam int unsigned BIT_CNT_W_DEF  = 4;

  localparam int unsigned PRESCALE_MIN = 8;
  localparam int unsigned PRESCALE_MAX = 32;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Legal oversampling ratios are even and within [PRESCALE_MIN, PRESCALE_MAX].
  function automatic logic prescale_legal(input int unsigned p);
    return (p[0] == 1'b0) && (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX);
  endfunction

endpackage

// File: rtl/edge_bit_counter_rx.sv
// Bit-period timing for the UART receiver.
// Counts oversampling edges inside a bit period and completed bit periods.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   enable      - sampling enable from the RX FSM
//   prescale_q  - frozen oversampling ratio
//   legal       - prescale_q is a supported ratio
//   edge_cnt    - edge index within the current bit period
//   bit_cnt     - completed bit periods since enable (wraps)
//   bit_done    - high during the last edge of each bit period
module edge_bit_counter_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale_q,
  input  logic                  legal,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done
);

  localparam logic [PRESCALE_W-1:0] EdgeOne = 1;
  localparam logic [BIT_CNT_W-1:0]  CntOne  = 1;

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  last_edge;

  // Depends on registers only. While idle edge_cnt is 0 and any legal ratio
  // has prescale_q-1 >= 7, so this cannot fire outside a running frame.
  assign last_edge = legal && (edge_cnt_q == prescale_q - EdgeOne);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!(enable && legal)) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (last_edge) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + CntOne;
    end else begin
      edge_cnt_d = edge_cnt_q + EdgeOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;
  assign bit_done = last_edge;

endmodule

// File: rtl/data_sampling_rx.sv
// Oversampling bit sampler for the UART receiver.
// Takes three samples of RX_IN around mid-bit and majority-votes them; also
// provides bit-period timing to the RX FSM.
// Ports:
//   CLK_data_samp      - oversampling clock
//   RST_data_samp      - synchronous active-high reset
//   dat_samp_en        - sampling enable, high for the whole frame
//   prescale           - oversampling ratio (legal: even, 8..32)
//   RX_IN              - serial line, already synchronous
//   sample_bit_par_chk - majority-voted bit of the current bit period
//   sample_valid       - one-cycle pulse after sample_bit_par_chk updates
//   bit_done           - one-cycle pulse on the last edge of each bit period
//   bit_cnt            - completed bit periods since enable
//   cfg_err            - high while enabled with an illegal prescale
module data_sampling_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned BIT_CNT_W  = BIT_CNT_W_DEF
) (
  input  logic                  CLK_data_samp,
  input  logic                  RST_data_samp,
  input  logic                  dat_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  RX_IN,
  output logic                  sample_bit_par_chk,
  output logic                  sample_valid,
  output logic                  bit_done,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  cfg_err
);

  localparam logic [PRESCALE_W-1:0] One         = 1;
  localparam logic [PRESCALE_W-1:0] PrescaleRst = PRESCALE_W'(PRESCALE_MIN);

  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] mid;
  logic                  legal, run;
  logic                  s0_q, s1_q;
  logic                  sample_bit_q, sample_valid_q, cfg_err_q;
  logic                  at_s0, at_s1, at_vote;

  assign legal = prescale_legal(32'(prescale_q));
  assign run   = dat_samp_en && legal;
  assign mid   = prescale_q >> 1;

  assign at_s0   = run && (edge_cnt == mid - One);
  assign at_s1   = run && (edge_cnt == mid);
  assign at_vote = run && (edge_cnt == mid + One);

  edge_bit_counter_rx #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_edge_bit_counter (
    .clk        (CLK_data_samp),
    .rst        (RST_data_samp),
    .enable     (dat_samp_en),
    .prescale_q (prescale_q),
    .legal      (legal),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .bit_done   (bit_done)
  );

  always_ff @(posedge CLK_data_samp) begin
    if (RST_data_samp) begin
      prescale_q     <= PrescaleRst;
      s0_q           <= 1'b1;
      s1_q           <= 1'b1;
      sample_bit_q   <= 1'b1;
      sample_valid_q <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      cfg_err_q      <= dat_samp_en && !legal;
      sample_valid_q <= at_vote;
      if (!dat_samp_en) begin
        // Ratio is only captured between frames; partial samples are dropped.
        prescale_q <= prescale;
        s0_q       <= 1'b1;
        s1_q       <= 1'b1;
      end else begin
        if (at_s0) s0_q <= RX_IN;
        if (at_s1) s1_q <= RX_IN;
        if (at_vote) sample_bit_q <= majority3(s0_q, s1_q, RX_IN);
      end
    end
  end

  assign sample_bit_par_chk = sample_bit_q;
  assign sample_valid       = sample_valid_q;
  assign cfg_err            = cfg_err_q;

endmodule
